// File: rtl/bram_fifo_ctrl.sv
// Ready/valid FWFT FIFO controller driving a dual-port, 1-cycle-latency BRAM,
// with a 2-entry prefetch buffer. Optional peak-occupancy tracking via FIFO_STATS_EN.
module bram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  bram_readEnable,
    output logic [ADDR_WIDTH-1:0] bram_readAddress,
    input  logic [DATA_WIDTH-1:0] bram_readData,
    output logic                  bram_writeEnable,
    output logic [ADDR_WIDTH-1:0] bram_writeAddress,
    output logic [DATA_WIDTH-1:0] bram_writeData,
    output logic [ADDR_WIDTH+1:0] high_water
);

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   bram_cnt_q, bram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  buf_head_q, buf_head_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [ADDR_WIDTH+1:0] count_q, count_d;

    logic       push_fire;
    logic       pop_fire;
    logic       rd_fire;
    logic       buf_tail;
    logic [2:0] slots_after_pop;

    assign push_ready = (bram_cnt_q != FULL_CNT);
    assign pop_valid  = (buf_cnt_q != 2'd0);
    assign pop_data   = buf_data_q[buf_head_q];
    assign count      = count_q;

    assign push_fire = push_valid & push_ready;
    assign pop_fire  = pop_valid & pop_ready;

    // A same-cycle pop frees a buffer slot, so it is credited before deciding to
    // prefetch; this keeps one read in flight every cycle when streaming.
    assign slots_after_pop = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop_fire);
    assign rd_fire         = (bram_cnt_q != '0) & (slots_after_pop < 3'd2);

    assign bram_readEnable   = rd_fire;
    assign bram_readAddress  = rd_ptr_q;
    assign bram_writeEnable  = push_fire;
    assign bram_writeAddress = wr_ptr_q;
    assign bram_writeData    = push_data;

    // Captured word lands behind the current head; head+cnt mod 2.
    assign buf_tail = buf_head_q ^ buf_cnt_q[0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push_fire);
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(rd_fire);
        bram_cnt_d = bram_cnt_q + (ADDR_WIDTH+1)'(push_fire) - (ADDR_WIDTH+1)'(rd_fire);
        inflight_d = rd_fire;
        buf_cnt_d  = buf_cnt_q + 2'(inflight_q) - 2'(pop_fire);
        buf_head_d = buf_head_q ^ pop_fire;
        count_d    = count_q + (ADDR_WIDTH+2)'(push_fire) - (ADDR_WIDTH+2)'(pop_fire);
        buf_data_d = buf_data_q;
        if (inflight_q) begin
            buf_data_d[buf_tail] = bram_readData;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            bram_cnt_q <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf_head_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            bram_cnt_q <= bram_cnt_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf_head_q <= buf_head_d;
            count_q    <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    buf_data_q[gi] <= '0;
                end else begin
                    buf_data_q[gi] <= buf_data_d[gi];
                end
            end
        end
    endgenerate

`ifdef FIFO_STATS_EN
    logic [ADDR_WIDTH+1:0] high_water_q, high_water_d;

    always_comb begin
        high_water_d = (count_d > high_water_q) ? count_d : high_water_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            high_water_q <= '0;
        end else begin
            high_water_q <= high_water_d;
        end
    end

    assign high_water = high_water_q;
`else
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl: directed stimulus, queue of expected pops,
// decoupled monitor, 1-cycle registered BRAM model.
module tb_bram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          push_valid, push_ready, pop_valid, pop_ready;
    logic [DW-1:0] push_data, pop_data;
    logic [AW+1:0] count, high_water;
    logic          bram_readEnable, bram_writeEnable;
    logic [AW-1:0] bram_readAddress, bram_writeAddress;
    logic [DW-1:0] bram_readData, bram_writeData;

    bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_data        (push_data),
        .pop_valid        (pop_valid),
        .pop_ready        (pop_ready),
        .pop_data         (pop_data),
        .count            (count),
        .bram_readEnable  (bram_readEnable),
        .bram_readAddress (bram_readAddress),
        .bram_readData    (bram_readData),
        .bram_writeEnable (bram_writeEnable),
        .bram_writeAddress(bram_writeAddress),
        .bram_writeData   (bram_writeData),
        .high_water       (high_water)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (bram_writeEnable) mem[bram_writeAddress] <= bram_writeData;
        if (bram_readEnable)  bram_readData <= mem[bram_readAddress];
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    int            model_cnt = 0;
    int            model_wp = 0;
    int            pop_seen = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus side: every accepted push becomes an expected pop.
    always @(negedge clock) begin
        if (reset && push_valid && push_ready) exp_q.push_back(push_data);
    end

    // Monitor: compares every pop against the queue and tracks occupancy.
    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            model_cnt = 0;
            model_wp  = 0;
        end else begin
            check("count", 64'(count), 64'(model_cnt));
            check("wr_en", 64'(bram_writeEnable), 64'(push_valid && push_ready));
            if (push_valid && push_ready) begin
                check("wr_addr", 64'(bram_writeAddress), 64'(model_wp % DEPTH));
                model_wp++;
                model_cnt++;
            end
            if (pop_valid && pop_ready) begin
                pop_seen++;
                model_cnt--;
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 64'(pop_data), 64'hDEAD_0000_0000);
                end else begin
                    check("pop_data", 64'(pop_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_one(input logic [DW-1:0] d);
        logic got;
        got = 1'b0;
        push_valid = 1'b1;
        push_data  = d;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clock);
            if (push_ready) got = 1'b1;
            @(posedge clock);
            #1;
        end
        push_valid = 1'b0;
        if (!got) check("push_timeout", 64'(got), 64'd1);
    endtask

    task automatic wait_empty(input int budget);
        logic done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clock);
            if (count == '0 && !pop_valid) done = 1'b1;
        end
        check("drained", 64'(done), 64'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        logic [AW+1:0] c0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        push_data  = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_count",    64'(count), 64'd0);
        check("rst_pop_valid",64'(pop_valid), 64'd0);
        check("rst_pop_data", 64'(pop_data), 64'd0);
        check("rst_push_rdy", 64'(push_ready), 64'd1);
        check("rst_hw",       64'(high_water), 64'd0);
        check("rst_rd_en",    64'(bram_readEnable), 64'd0);
        reset = 1'b1;

        // First-word latency: push at edge 1, visible after edge 3
        push_valid = 1'b1;
        push_data  = 32'hA5A5_A5A5;
        @(posedge clock); #1;
        push_valid = 1'b0;
        check("lat_e1", 64'(pop_valid), 64'd0);
        @(posedge clock); #1;
        check("lat_e2", 64'(pop_valid), 64'd0);
        @(posedge clock); #1;
        check("lat_e3", 64'(pop_valid), 64'd1);
        check("lat_data", 64'(pop_data), 64'hA5A5_A5A5);
        pop_ready = 1'b1;
        @(posedge clock); #1;
        pop_ready = 1'b0;
        check("lat_empty", 64'(count), 64'd0);

        // Fill to MEM_DEPTH+2 with no pops
        for (int i = 0; i < DEPTH + 2; i++) push_one(DW'(i));
        @(negedge clock);
        check("full_count", 64'(count), 64'(DEPTH + 2));
        check("full_push_rdy", 64'(push_ready), 64'd0);
        @(posedge clock); #1;
        push_valid = 1'b1;
        push_data  = 32'h0000_0999;
        repeat (3) @(posedge clock);
        #1;
        push_valid = 1'b0;
        check("full_hold", 64'(count), 64'(DEPTH + 2));

        // Drain: one pop per cycle, no gaps
        p0 = pop_seen;
        pop_ready = 1'b1;
        repeat (DEPTH + 2) @(posedge clock);
        #1;
        check("drain_gapless", 64'(pop_seen - p0), 64'(DEPTH + 2));
        pop_ready = 1'b0;
        wait_empty(5);

        // Streaming push+pop across pointer wrap
        push_valid = 1'b1;
        pop_ready  = 1'b1;
        p0 = 0;
        c0 = '0;
        for (int i = 0; i < 1000; i++) begin
            push_data = DW'(32'h1000 + i);
            if (i == 10) begin
                p0 = pop_seen;
                c0 = count;
            end
            @(posedge clock);
            #1;
        end
        check("stream_rate", 64'(pop_seen - p0), 64'd990);
        check("stream_count", 64'(count), 64'(c0));
        check("stream_primed", 64'(c0 <= 3 && c0 != 0), 64'd1);
        push_valid = 1'b0;
        wait_empty(20);

        // Random handshakes
        for (int i = 0; i < 10000; i++) begin
            push_valid = 1'($urandom_range(0, 1));
            pop_ready  = 1'($urandom_range(0, 1));
            push_data  = $urandom;
            @(posedge clock);
            #1;
        end
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        wait_empty(DEPTH + 20);
        pop_ready = 1'b0;

        // Reset mid-stream with count 5 and a read in flight
        for (int i = 0; i < 5; i++) push_one(DW'(32'h50 + i));
        push_valid = 1'b1;
        push_data  = 32'h55;
        pop_ready  = 1'b1;
        @(posedge clock); #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        check("pre_rst_count", 64'(count), 64'd5);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_pop_valid", 64'(pop_valid), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        p0 = pop_seen;
        push_one(32'h1);
        pop_ready = 1'b1;
        wait_empty(10);
        repeat (4) @(posedge clock);
        #1;
        check("post_rst_pops", 64'(pop_seen - p0), 64'd1);
        pop_ready = 1'b0;

        // Peak occupancy
        for (int i = 0; i < 7; i++) push_one(DW'(32'h70 + i));
        pop_ready = 1'b1;
        wait_empty(20);
        pop_ready = 1'b0;
`ifdef FIFO_STATS_EN
        check("high_water", 64'(high_water), 64'd7);
`else
        check("high_water", 64'(high_water), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
